// File: rtl/ppc_types.sv
// ----------------------------------------------------------------------------
// ppc_types
//   Shared types for the fixed-point writeback path.
//   - wb_result_t : one result record as produced by an execution unit and
//                   written to the GPR/CR file.
//   - wb_unit_e   : execution unit index. The order of the entries sets the
//                   requester index order seen by the writeback arbiter.
//   - WB_NUM_UNITS: number of fixed-point units that share the writeback port.
// ----------------------------------------------------------------------------
package ppc_types;

  typedef struct packed {
    logic [0:31] value;      // result value (big-endian bit numbering)
    logic [0:4]  addr;       // destination GPR
    logic        alter_reg;  // write value to GPR[addr]
    logic        alter_cr;   // write cr field
    logic [0:3]  cr;         // condition register field
  } wb_result_t;

  typedef enum logic [2:0] {
    WB_ADD_SUB = 3'd0,
    WB_MUL     = 3'd1,
    WB_DIV     = 3'd2,
    WB_LOG     = 3'd3,
    WB_ROT     = 3'd4,
    WB_CMP     = 3'd5,
    WB_SYS     = 3'd6,
    WB_TRAP    = 3'd7
  } wb_unit_e;

  localparam int WB_NUM_UNITS = 8;
  localparam int WB_RES_W     = $bits(wb_result_t);

endpackage

// File: rtl/rr_priority_picker.sv
// ----------------------------------------------------------------------------
// rr_priority_picker
//   Combinational round-robin picker. Scans req_i starting at ptr_i and
//   wrapping at NUM_UNITS-1 -> 0; the first set bit wins.
//   Ports:
//     req_i   [NUM_UNITS]   request vector
//     ptr_i   [IDX_W]       index with highest priority (must be < NUM_UNITS)
//     grant_o [NUM_UNITS]   one-hot winner, zero when nothing requests
//     idx_o   [IDX_W]       binary index of the winner, 0 when nothing requests
//     any_o                 at least one request present
// ----------------------------------------------------------------------------
module rr_priority_picker #(
  parameter  int NUM_UNITS = 8,
  localparam int IDX_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic [NUM_UNITS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic [NUM_UNITS-1:0] grant_o,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 any_o
);

  // One extra bit holds ptr + offset before the wrap, so the sum never
  // overflows and the wrap is an explicit subtraction rather than a modulo
  // that would only work for power-of-two unit counts.
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_UNITS)) begin
        sum = sum - (IDX_W+1)'(NUM_UNITS);
      end
      cand = sum[IDX_W-1:0];
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// ----------------------------------------------------------------------------
// writeback_arbiter
//   Round-robin arbiter that shares the single GPR/CR writeback port between
//   the fixed-point execution units. One grant per cycle into a single output
//   register; a result accepted in cycle N is presented in cycle N+1.
//   Ports:
//     clk          clock, rising edge
//     rst          synchronous reset, active-high (dominates flush)
//     flush        synchronous flush, active-high: drops the held result
//     req_valid    [NUM_UNITS]        unit i holds a result
//     req_ready    [NUM_UNITS]        unit i result taken this cycle (one-hot/0)
//     req_result   [NUM_UNITS*RES_W]  unit i record at [i*RES_W +: RES_W]
//     wb_valid                        output register holds a result
//     wb_ready                        register file takes wb_result
//     wb_result    [RES_W]            registered result record
//     wb_grant_id  [$clog2(NUM_UNITS)] unit that produced wb_result
//   req_ready is combinational from req_valid, wb_ready and internal state;
//   requesters must not make req_valid depend on req_ready.
// ----------------------------------------------------------------------------
module writeback_arbiter
  import ppc_types::*;
#(
  parameter int NUM_UNITS = WB_NUM_UNITS,
  parameter int RES_W     = $bits(wb_result_t)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_UNITS-1:0]          req_valid,
  output logic [NUM_UNITS-1:0]          req_ready,
  input  logic [NUM_UNITS*RES_W-1:0]    req_result,
  output logic                          wb_valid,
  input  logic                          wb_ready,
  output logic [RES_W-1:0]              wb_result,
  output logic [$clog2(NUM_UNITS)-1:0]  wb_grant_id
);

  localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic                 load_en;
  logic [NUM_UNITS-1:0] pick_grant;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  logic [IDX_W-1:0]     ptr_q,         ptr_d;
  logic                 wb_valid_q,    wb_valid_d;
  logic [RES_W-1:0]     wb_result_q,   wb_result_d;
  logic [IDX_W-1:0]     wb_grant_id_q, wb_grant_id_d;

  rr_priority_picker #(
    .NUM_UNITS (NUM_UNITS)
  ) u_picker (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // NOTE: combinational logic uses blocking '=' and assigns every output a
  // default first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    // The register can load when it is empty or being drained this cycle.
    // Reset and flush both suppress any grant so no record is consumed.
    load_en   = !rst && !flush && (!wb_valid_q || wb_ready);
    req_ready = load_en ? pick_grant : '0;

    ptr_d         = ptr_q;
    wb_valid_d    = wb_valid_q;
    wb_result_d   = wb_result_q;
    wb_grant_id_d = wb_grant_id_q;

    if (load_en) begin
      wb_valid_d = pick_any;
      if (pick_any) begin
        wb_result_d   = req_result[pick_idx*RES_W +: RES_W];
        wb_grant_id_d = pick_idx;
        // Winner drops to lowest priority; explicit wrap keeps the pointer
        // inside 0..NUM_UNITS-1 for any unit count.
        ptr_d = (pick_idx == IDX_W'(NUM_UNITS-1)) ? '0 : pick_idx + IDX_W'(1);
      end
    end else if (flush) begin
      // Flush discards the held record; the pointer keeps its position.
      wb_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order. The payload register is
  // reset as well because its reset value of zero is visible on wb_result.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q         <= '0;
      wb_valid_q    <= 1'b0;
      wb_result_q   <= '0;
      wb_grant_id_q <= '0;
    end else begin
      ptr_q         <= ptr_d;
      wb_valid_q    <= wb_valid_d;
      wb_result_q   <= wb_result_d;
      wb_grant_id_q <= wb_grant_id_d;
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_result   = wb_result_q;
  assign wb_grant_id = wb_grant_id_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// ----------------------------------------------------------------------------
// tb_writeback_arbiter
//   Directed scenarios (reset, round-robin order, backpressure, sparse wrap,
//   flush, mid-transfer reset) followed by a randomized phase with a record
//   scoreboard and a fairness bound. A behavioural model (integer pointer,
//   modular scan) predicts req_ready and the output register every cycle.
// ----------------------------------------------------------------------------
module tb_writeback_arbiter;
  import ppc_types::*;

  localparam int N  = 8;
  localparam int RW = $bits(wb_result_t);

  logic            clk = 1'b0;
  logic            rst, flush, wb_ready;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*RW-1:0] req_result;
  logic            wb_valid;
  logic [RW-1:0]   wb_result;
  logic [2:0]      wb_grant_id;

  wb_result_t rec [N];

  always_comb begin
    req_result = '0;
    for (int i = 0; i < N; i++) req_result[i*RW +: RW] = rec[i];
  end

  always #5 clk = ~clk;

  writeback_arbiter #(.NUM_UNITS(N), .RES_W(RW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_result  (req_result),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_result   (wb_result),
    .wb_grant_id (wb_grant_id)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit         m_valid = 1'b0;
  wb_result_t m_res   = '0;
  int         m_id    = 0;
  int         m_ptr   = 0;

  // Scoreboard of accepted records, in acceptance order
  typedef struct {
    int         id;
    wb_result_t r;
  } sb_t;
  sb_t sbq[$];
  bit  sb_en = 1'b0;

  // Values observed just before the most recent clock edge
  logic [N-1:0]  obs_rdy;
  logic          obs_valid;
  logic [RW-1:0] obs_res;
  logic [2:0]    obs_id;

  int wait_cnt [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // First requesting index at or after p, scanning modulo N; -1 if none.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic wb_result_t rand_rec();
    wb_result_t r;
    r.value     = $urandom;
    r.addr      = 5'($urandom);
    r.alter_reg = 1'($urandom);
    r.alter_cr  = 1'($urandom);
    r.cr        = 4'($urandom);
    return r;
  endfunction

  // One clock cycle: inputs are already driven; check req_ready, clock,
  // advance the model, then check the registered outputs.
  task automatic step();
    int           g;
    logic [N-1:0] exp_rdy;
    sb_t          e;
    #1;
    g       = pick(req_valid, m_ptr);
    exp_rdy = '0;
    if (!rst && !flush && (!m_valid || wb_ready) && g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    obs_rdy   = req_ready;
    obs_valid = wb_valid;
    obs_res   = wb_result;
    obs_id    = wb_grant_id;

    @(posedge clk);

    if (sb_en && !rst && !flush) begin
      if (obs_valid && wb_ready) begin
        if (sbq.size() == 0) begin
          check("sb_extra", 64'(1), 64'(0));
        end else begin
          e = sbq.pop_front();
          check("sb_id", 64'(obs_id), 64'(e.id));
          check("sb_rec", 64'(obs_res), 64'(e.r));
        end
      end
      for (int i = 0; i < N; i++) begin
        if (obs_rdy[i]) begin
          e.id = i;
          e.r  = rec[i];
          sbq.push_back(e);
        end
      end
    end

    if (rst) begin
      m_valid = 1'b0;
      m_res   = '0;
      m_id    = 0;
      m_ptr   = 0;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (!m_valid || wb_ready) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_res   = rec[g];
        m_id    = g;
        m_ptr   = (g + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end

    #1;
    check("wb_valid", 64'(wb_valid), 64'(m_valid));
    if (m_valid || rst) begin
      check("wb_id", 64'(wb_grant_id), 64'(m_id));
      check("wb_result", 64'(wb_result), 64'(m_res));
    end
  endtask

  wb_result_t r_out;

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    wb_ready  = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      rec[i]       = '0;
      rec[i].value = 32'h1000_0000 + i;
      rec[i].addr  = 5'(i);
      wait_cnt[i]  = 0;
    end

    // Reset held two cycles with every unit requesting
    step();
    step();
    check("rst_valid", 64'(wb_valid), 64'(0));
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_result", 64'(wb_result), 64'(0));
    rst = 1'b0;
    step();
    check("rst_g0", 64'(wb_grant_id), 64'(0));

    // Round-robin with all units requesting: 1..7 then back to 0
    for (int k = 1; k <= N; k++) begin
      step();
      check("rr_seq", 64'(wb_grant_id), 64'(k % N));
    end

    // Backpressure: unit 2 holds 0xDEADBEEF while wb_ready is low
    req_valid       = 8'b0000_0100;
    rec[2].value    = 32'hDEAD_BEEF;
    step();
    wb_ready  = 1'b0;
    req_valid = '1;
    for (int k = 0; k < 3; k++) begin
      step();
      r_out = wb_result;
      check("bp_hold", 64'(r_out.value), 64'(32'hDEAD_BEEF));
      check("bp_id", 64'(wb_grant_id), 64'(2));
      check("bp_ready", 64'(obs_rdy), 64'(0));
    end
    wb_ready  = 1'b1;
    req_valid = 8'b0010_0010;
    step();
    check("bp_next", 64'(wb_grant_id), 64'(5));

    // Sparse requests across the wrap: pointer moves to 7, then 1/6 alternate
    req_valid = 8'b0100_0000;
    step();
    check("sp_g6", 64'(wb_grant_id), 64'(6));
    req_valid = 8'b0100_0010;
    step();
    check("sp_wrap1", 64'(wb_grant_id), 64'(1));
    step();
    check("sp_g6b", 64'(wb_grant_id), 64'(6));
    step();
    check("sp_wrap2", 64'(wb_grant_id), 64'(1));

    // Flush drops a pending result and blocks the grant for one cycle
    req_valid = 8'b0001_0000;
    step();
    check("fl_g4", 64'(wb_grant_id), 64'(4));
    flush     = 1'b1;
    req_valid = 8'b0010_0000;
    step();
    check("fl_ready", 64'(obs_rdy), 64'(0));
    check("fl_valid", 64'(wb_valid), 64'(0));
    flush = 1'b0;
    step();
    check("fl_g5", 64'(wb_grant_id), 64'(5));
    check("fl_v5", 64'(wb_valid), 64'(1));

    // Reset in the middle of a stalled transfer, together with flush
    wb_ready = 1'b0;
    rst      = 1'b1;
    flush    = 1'b1;
    step();
    check("mrst_valid", 64'(wb_valid), 64'(0));
    check("mrst_result", 64'(wb_result), 64'(0));
    rst      = 1'b0;
    flush    = 1'b0;
    wb_ready = 1'b1;
    step();
    check("mrst_g5", 64'(wb_grant_id), 64'(5));

    // Randomized traffic with scoreboard and fairness bound
    rst       = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
    sbq.delete();
    sb_en = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      wb_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          rec[i]       = rand_rec();
          wait_cnt[i]  = 0;
        end
      end
      step();
      for (int i = 0; i < N; i++) begin
        if (obs_rdy[i]) begin
          check("fair", 64'(wait_cnt[i] <= N - 1), 64'(1));
          req_valid[i] = 1'b0;
        end else if (req_valid[i] && |obs_rdy) begin
          wait_cnt[i]++;
        end
      end
    end

    // Drain: no new requests, register file always ready
    wb_ready = 1'b1;
    for (int c = 0; c < 3 * N; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (obs_rdy[i]) req_valid[i] = 1'b0;
      end
    end
    check("sb_drain", 64'(sbq.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
